op_sequencer: RTL and testbench
===============================

Name: op_sequencer

Overview:
Parametrised control FSM for the p02 iterative arithmetic datapath. It sequences loading of NUM_OPERANDS operands and launches the datapath. It then runs the datapath for a bounded number of iterations, or ends early on the datapath's done. It supports abort and an optional auto-start mode. It sits between the host-side strobes (start, load, abort) and the datapath's operand-select, go and stop controls.

Parameters:
NUM_OPERANDS, 2, number of operands loaded before processing; must be >= 1.
ITERATIONS, 16, maximum processing cycles; must be >= 2.
AUTO_START, 0, 1 = enter PROCESSING directly after the last operand is loaded, without start.
SEL_W, (NUM_OPERANDS>1 ? $clog2(NUM_OPERANDS) : 1), derived; width of sel.
CNT_W, $clog2(ITERATIONS), derived; width of iter_cnt.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  launch request; level sampled each cycle.
load  in  1  operand-valid strobe from the host.
abort  in  1  cancel the current operation.
done  in  1  early-termination flag from the datapath.
sel  out  SEL_W  index of the operand currently being loaded.
load_en  out  1  operand register write enable to the datapath.
go  out  1  one-cycle launch pulse to the datapath.
stop  out  1  one-cycle completion pulse.
busy  out  1  high in every state except IDLE.
iter_cnt  out  CNT_W  current processing iteration.
err  out  1  one-cycle error/abort pulse.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, sel=0, iter_cnt=0, go=0, stop=0, busy=0, err=0. load_en=0 while rst is high.
- States: IDLE, LOAD, READY, PROCESSING, DONE. Encode DONE as its own state; it must not alias IDLE.
- load_en is combinational: load_en = load & (state==IDLE | state==LOAD). Every other output is registered or decoded only from registered state.
- IDLE:
  - A load is accepted with sel=0.
  - If NUM_OPERANDS==1, the accepted load goes to READY, or to PROCESSING when AUTO_START=1.
  - Otherwise the accepted load sets sel=1 and goes to LOAD.
- LOAD:
  - Each accepted load increments sel.
  - The load with sel==NUM_OPERANDS-1 goes to READY, or to PROCESSING when AUTO_START=1, and clears sel to 0.
- READY: start=1 goes to PROCESSING. A load in READY is ignored (load_en=0).
- PROCESSING:
  - iter_cnt starts at 0 and increments every cycle.
  - go = (state==PROCESSING && iter_cnt==0), so go is high exactly in the first PROCESSING cycle.
  - Exit to DONE when done=1 or iter_cnt==ITERATIONS-1.
  - Maximum PROCESSING duration is ITERATIONS cycles.
- DONE: lasts exactly one cycle with stop=1. iter_cnt clears to 0. The next state is IDLE.
- busy = (state != IDLE).
- Start before all operands are loaded (start=1 in IDLE or LOAD): start is ignored, the state is unchanged, and err=1 in the next cycle.
- Abort: abort=1 in LOAD, READY or PROCESSING forces IDLE next cycle, clears sel and iter_cnt, suppresses stop, and sets err=1 in the next cycle. Abort in IDLE or DONE is ignored.
- Priority:
  - abort > done > iteration terminal > start > load.
  - done and terminal count in the same cycle give a single transition to DONE.
  - start and load together in READY: start wins.
  - start and load together in LOAD: the load is accepted and the start flags err.
- A start held high across DONE→IDLE does not relaunch. A new operation requires a fresh load sequence.
- Reset mid-operation: immediate return to the reset values above, with no stop pulse.

Decomposition:
- Shared package p02_pkg holds the seq_state_t enum (IDLE, LOAD, READY, PROCESSING, DONE), the localparam widths, and a `function automatic clog2_min1`.
- One sub-module, iter_counter: parametrised CNT_W up-counter with clr, en and terminal-count output. It is instantiated for iter_cnt.
- sel is kept inline.

Test Plan:
- NUM_OPERANDS=2, ITERATIONS=4, AUTO_START=0. Sequence: load, load, start, then 4 idle cycles. Required: load_en high on both loads with sel=0 then sel=1. go high 1 cycle, iter_cnt 0,1,2,3, stop high on the 5th cycle after start, busy low the cycle after stop.
- Same configuration, done=1 while iter_cnt==1 -> DONE next cycle, stop pulses once, no further increment.
- start after only one load (sel=1) -> state stays LOAD, err=1 for 1 cycle. A second load then start launches normally.
- AUTO_START=1, two loads, start held 0 -> go asserted the cycle after the second load, stop after 4 PROCESSING cycles.
- abort at iter_cnt==2 -> IDLE next cycle, err=1 for 1 cycle, stop never asserted, iter_cnt=0. Also abort and done asserted together -> abort wins.
- rst=1 asserted asynchronously mid-PROCESSING (between edges) -> all outputs at reset values immediately. After release, a load is accepted with sel=0.

Source files
------------

// File: rtl/p02_pkg.sv
// p02_pkg: shared types and helpers for the p02 iterative datapath controller.
//   seq_state_t    - sequencer state encoding (DONE is a distinct state from IDLE)
//   DEF_*          - default configuration of op_sequencer
//   clog2_min1()   - ceil(log2(n)), at least 1, for index widths that must not collapse to 0
package p02_pkg;

    localparam int unsigned DEF_NUM_OPERANDS = 2;
    localparam int unsigned DEF_ITERATIONS   = 16;
    localparam bit          DEF_AUTO_START   = 1'b0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        READY      = 3'd2,
        PROCESSING = 3'd3,
        DONE       = 3'd4
    } seq_state_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/iter_counter.sv
// iter_counter: CNT_W-bit up-counter with synchronous clear and count enable.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   clr   in   synchronous clear (wins over en)
//   en    in   increment enable
//   count out  current count
//   tc    out  high while count == MAX_COUNT
module iter_counter #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned MAX_COUNT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(MAX_COUNT));

endmodule

// File: rtl/op_sequencer.sv
// op_sequencer: control FSM for the p02 iterative arithmetic datapath.
// Loads NUM_OPERANDS operands, launches the datapath, then runs it for at most
// ITERATIONS cycles or until the datapath reports done. Supports abort and auto-start.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   launch request (level, sampled each cycle)
//   load     in   operand-valid strobe from the host
//   abort    in   cancel current operation
//   done     in   early-termination flag from the datapath
//   sel      out  index of operand being loaded
//   load_en  out  operand register write enable (combinational)
//   go       out  high in the first PROCESSING cycle only
//   stop     out  high for the single DONE cycle
//   busy     out  high in every state except IDLE
//   iter_cnt out  current processing iteration
//   err      out  one-cycle pulse after an early start or an abort
module op_sequencer
    import p02_pkg::*;
#(
    parameter int unsigned NUM_OPERANDS = DEF_NUM_OPERANDS,
    parameter int unsigned ITERATIONS   = DEF_ITERATIONS,
    parameter bit          AUTO_START   = DEF_AUTO_START,
    parameter int unsigned SEL_W        = clog2_min1(NUM_OPERANDS),
    parameter int unsigned CNT_W        = $clog2(ITERATIONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load,
    input  logic             abort,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic             load_en,
    output logic             go,
    output logic             stop,
    output logic             busy,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             err
);

    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_OPERANDS - 1);
    localparam seq_state_t       AFTER_LOAD = AUTO_START ? PROCESSING : READY;

    seq_state_t state;
    logic       cnt_en;
    logic       cnt_clr;
    logic       cnt_tc;

    // Counter runs only in PROCESSING and is cleared on the way out, so it reads 0
    // in DONE and never wraps past ITERATIONS-1.
    assign cnt_en  = (state == PROCESSING);
    assign cnt_clr = cnt_en & (abort | done | cnt_tc);

    iter_counter #(
        .CNT_W     (CNT_W),
        .MAX_COUNT (ITERATIONS - 1)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (iter_cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    // abort is ignored here; start is ignored but flagged
                    if (start) begin
                        err <= 1'b1;
                    end
                    if (load) begin
                        if (NUM_OPERANDS == 1) begin
                            state <= AFTER_LOAD;
                        end else begin
                            sel   <= SEL_W'(1);
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        sel   <= '0;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        // start with load: the load still proceeds, start only flags err
                        if (start) begin
                            err <= 1'b1;
                        end
                        if (load) begin
                            if (sel == SEL_LAST) begin
                                sel   <= '0;
                                state <= AFTER_LOAD;
                            end else begin
                                sel <= sel + 1'b1;
                            end
                        end
                    end
                end
                READY: begin
                    if (abort) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (start) begin
                        state <= PROCESSING;
                    end
                end
                PROCESSING: begin
                    if (abort) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (done || cnt_tc) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    sel   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Gated by rst so no write strobe reaches the datapath while in reset.
    assign load_en = load & ~rst & ((state == IDLE) | (state == LOAD));
    assign go      = (state == PROCESSING) && (iter_cnt == '0);
    assign stop    = (state == DONE);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: directed, self-checking bench for op_sequencer.
// DUT a: NUM_OPERANDS=2, ITERATIONS=4, AUTO_START=0. DUT b: same with AUTO_START=1.
module tb_op_sequencer;

    localparam int unsigned NUM  = 2;
    localparam int unsigned ITER = 4;
    localparam int unsigned SW   = 1;
    localparam int unsigned CW   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_a, load_a, abort_a, done_a;
    logic [SW-1:0] sel_a;
    logic          load_en_a, go_a, stop_a, busy_a, err_a;
    logic [CW-1:0] iter_cnt_a;

    logic          start_b, load_b, abort_b, done_b;
    logic [SW-1:0] sel_b;
    logic          load_en_b, go_b, stop_b, busy_b, err_b;
    logic [CW-1:0] iter_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic          go;
        logic          stop;
        logic          busy;
        logic [CW-1:0] iter_cnt;
        logic          err;
    } exp_t;

    exp_t exp_q[$];

    op_sequencer #(
        .NUM_OPERANDS (NUM),
        .ITERATIONS   (ITER),
        .AUTO_START   (1'b0)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .load     (load_a),
        .abort    (abort_a),
        .done     (done_a),
        .sel      (sel_a),
        .load_en  (load_en_a),
        .go       (go_a),
        .stop     (stop_a),
        .busy     (busy_a),
        .iter_cnt (iter_cnt_a),
        .err      (err_a)
    );

    op_sequencer #(
        .NUM_OPERANDS (NUM),
        .ITERATIONS   (ITER),
        .AUTO_START   (1'b1)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .load     (load_b),
        .abort    (abort_b),
        .done     (done_b),
        .sel      (sel_b),
        .load_en  (load_en_b),
        .go       (go_b),
        .stop     (stop_b),
        .busy     (busy_b),
        .iter_cnt (iter_cnt_b),
        .err      (err_b)
    );

    function automatic exp_t mk(input int unsigned s, input int unsigned g, input int unsigned st,
                                input int unsigned b, input int unsigned it,
                                input int unsigned e);
        exp_t r;
        r.sel      = SW'(s);
        r.go       = g[0];
        r.stop     = st[0];
        r.busy     = b[0];
        r.iter_cnt = CW'(it);
        r.err      = e[0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle on DUT a: check load_en before the edge, queue the expected
    // post-edge outputs, clock, then pop and compare.
    task automatic step(input string tag, input logic s, input logic l, input logic a,
                        input logic d, input logic le, input exp_t e);
        exp_t got;
        start_a = s;
        load_a  = l;
        abort_a = a;
        done_a  = d;
        #1;
        chk({tag, " load_en"}, 32'(load_en_a), 32'(le));
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({tag, " sel"},      32'(sel_a),      32'(got.sel));
        chk({tag, " go"},       32'(go_a),       32'(got.go));
        chk({tag, " stop"},     32'(stop_a),     32'(got.stop));
        chk({tag, " busy"},     32'(busy_a),     32'(got.busy));
        chk({tag, " iter_cnt"}, 32'(iter_cnt_a), 32'(got.iter_cnt));
        chk({tag, " err"},      32'(err_a),      32'(got.err));
    endtask

    // Two loads then start from IDLE; leaves DUT a in PROCESSING with iter_cnt=0.
    task automatic launch(input string tag);
        step({tag, " ld0"},   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0));
        step({tag, " ld1"},   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 1, 0, 0));
        step({tag, " start"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 1, 0, 0));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        start_a = 1'b0; load_a = 1'b0; abort_a = 1'b0; done_a = 1'b0;
        start_b = 1'b0; load_b = 1'b0; abort_b = 1'b0; done_b = 1'b0;
        #1;
        chk("reset sel",      32'(sel_a),      0);
        chk("reset go",       32'(go_a),       0);
        chk("reset stop",     32'(stop_a),     0);
        chk("reset busy",     32'(busy_a),     0);
        chk("reset iter_cnt", 32'(iter_cnt_a), 0);
        chk("reset err",      32'(err_a),      0);
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full run to terminal count
        launch("t1");
        step("t1 it1",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 0));
        step("t1 it2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 2, 0));
        step("t1 it3",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 3, 0));
        step("t1 done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 1, 0, 0));
        step("t1 idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));

        // Early termination on done at iter_cnt==1
        launch("t2");
        step("t2 it1",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 0));
        step("t2 done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 0, 0));
        step("t2 idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));

        // Early start in LOAD, then normal launch, then abort at iter_cnt==2
        step("t3 ld0",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0));
        step("t3 early", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 0, 1));
        step("t3 ld1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 1, 0, 0));
        step("t3 start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 1, 0, 0));
        step("t3 it1",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 0));
        step("t3 it2",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 2, 0));
        step("t3 abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));
        step("t3 idle",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));

        // abort and done together: abort wins
        launch("t4");
        step("t4 abort+done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 1));
        step("t4 idle",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));

        // start+load in LOAD and READY, abort in READY, abort in IDLE
        step("t5 ld0",       1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0));
        step("t5 st+ld LOAD",  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 1, 0, 1));
        step("t5 st+ld READY", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 1, 0, 0));
        step("t5 abort proc",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));
        step("t5 ld0b",        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0));
        step("t5 ld1b",        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 1, 0, 0));
        step("t5 ld in READY", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 0));
        step("t5 abort READY", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));
        step("t5 abort IDLE",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));

        // start held across DONE->IDLE does not relaunch
        launch("t6");
        step("t6 done",      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 0, 0));
        step("t6 to idle",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));
        step("t6 held idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));
        step("t6 release",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));

        // Asynchronous reset mid-PROCESSING
        launch("t7");
        step("t7 it1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 0));
        #3;
        load_a = 1'b1;
        rst    = 1'b1;
        #1;
        chk("t7 rst sel",      32'(sel_a),      0);
        chk("t7 rst load_en",  32'(load_en_a),  0);
        chk("t7 rst go",       32'(go_a),       0);
        chk("t7 rst stop",     32'(stop_a),     0);
        chk("t7 rst busy",     32'(busy_a),     0);
        chk("t7 rst iter_cnt", 32'(iter_cnt_a), 0);
        chk("t7 rst err",      32'(err_a),      0);
        @(negedge clk);
        rst    = 1'b0;
        load_a = 1'b0;
        step("t7 ld after rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0));
        step("t7 cleanup",      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));

        // AUTO_START=1: go follows the second load without start
        load_b = 1'b1;
        #1;
        chk("b ld0 load_en", 32'(load_en_b), 1);
        @(posedge clk);
        #1;
        chk("b ld0 sel", 32'(sel_b), 1);
        @(posedge clk);
        #1;
        load_b = 1'b0;
        chk("b go",      32'(go_b),       1);
        chk("b it0",     32'(iter_cnt_b), 0);
        chk("b busy",    32'(busy_b),     1);
        for (int i = 1; i < int'(ITER); i++) begin
            @(posedge clk);
            #1;
            chk("b go low", 32'(go_b),       0);
            chk("b iter",   32'(iter_cnt_b), 32'(i));
            chk("b no stop", 32'(stop_b),    0);
        end
        @(posedge clk);
        #1;
        chk("b stop",      32'(stop_b), 1);
        chk("b stop busy", 32'(busy_b), 1);
        @(posedge clk);
        #1;
        chk("b stop end", 32'(stop_b), 0);
        chk("b idle",     32'(busy_b), 0);
        chk("b err",      32'(err_b),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
